// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: MDU funct codes and FSM state type.
package mdu_seq_pkg;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True for the funct codes that stall the pipeline when issued.
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/mdu_seq_div_radix2.sv
// Unsigned restoring radix-2 divider: one quotient bit per step, dividend shifts out of the quotient register.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // trial[WIDTH] is the borrow: set means the divisor did not fit.
  always_comb begin
    shifted = {remainder, quotient[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs       <= divisor;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        remainder <= trial[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= shifted[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// EX-stage multiply/divide sequencer owning HI/LO; stalls the pipeline while a divide iterates.
//   state  | meaning
//   S_IDLE | accepting MDU instructions; MTHI/MTLO complete here
//   S_DIV  | one divide step per cycle, pipeline stalled
//   S_DONE | result written to HI/LO, instruction leaves EX
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int DIV_STEPS = 32,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] res;
  logic               op_div;
  logic               wr_en;
  logic               neg_q;
  logic               neg_r;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               is_sdiv;
  logic               div_load;
  logic               div_step;

  always_comb begin
    prod_s   = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
    prod_u   = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    is_sdiv  = (funct_i == FN_DIV);
    dvd_mag  = (is_sdiv && a_i[WIDTH-1]) ? -a_i : a_i;
    dvs_mag  = (is_sdiv && b_i[WIDTH-1]) ? -b_i : b_i;
    quo_fix  = neg_q ? -quotient : quotient;
    rem_fix  = neg_r ? -remainder : remainder;
    div_load = (state == S_IDLE) && start_i && !flush_i &&
               ((funct_i == FN_DIV) || (funct_i == FN_DIVU)) && (b_i != '0);
    div_step = (state == S_DIV) && !flush_i;
    stall_o  = !flush_i &&
               (((state == S_IDLE) && start_i && is_muldiv(funct_i)) || (state == S_DIV));
    busy_o   = (state != S_IDLE);
  end

  div_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      res    <= '0;
      op_div <= 1'b0;
      wr_en  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            case (funct_i)
              FN_MTHI: hi_o <= a_i;
              FN_MTLO: lo_o <= a_i;
              FN_MULT, FN_MULTU: begin
                res    <= (funct_i == FN_MULT) ? prod_s : prod_u;
                op_div <= 1'b0;
                wr_en  <= 1'b1;
                state  <= S_DONE;
              end
              FN_DIV, FN_DIVU: begin
                op_div <= 1'b1;
                neg_q  <= is_sdiv && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                neg_r  <= is_sdiv && a_i[WIDTH-1];
                cnt    <= '0;
                // Divide by zero completes without touching HI/LO.
                if (b_i == '0) begin
                  wr_en <= 1'b0;
                  state <= S_DONE;
                end else begin
                  wr_en <= 1'b1;
                  state <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_STEPS - 1)) state <= S_DONE;
        end
        S_DONE: begin
          if (wr_en) begin
            hi_o <= op_div ? rem_fix : res[2*WIDTH-1:WIDTH];
            lo_o <= op_div ? quo_fix : res[WIDTH-1:0];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: reference HI/LO from native arithmetic, stall counts from issue rules.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [5:0]   funct_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         flush_i;
  logic         stall_o;
  logic         busy_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi;
  logic [W-1:0]   m_lo;

  always #5 clk = ~clk;

  mdu_seq #(.DIV_STEPS(32), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .funct_i (funct_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint sa;
    longint sb;
    longint p;
    logic [63:0] up;
    case (f)
      FN_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return 64'(p);
      end
      FN_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      FN_DIV: begin
        if (b == 32'd0) return {hi, lo};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return {32'(sa % sb), 32'(sa / sb)};
      end
      FN_DIVU: begin
        if (b == 32'd0) return {hi, lo};
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
        return {32'(sa % sb), 32'(sa / sb)};
      end
      FN_MTHI: return {a, lo};
      FN_MTLO: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int exp_stall(input logic [5:0] f, input logic [31:0] b);
    if (f == FN_MULT || f == FN_MULTU) return 1;
    if (f == FN_DIV || f == FN_DIVU) return (b == 32'd0) ? 1 : 33;
    return 0;
  endfunction

  // Issue one instruction, count stalled cycles, then compare HI/LO against the scoreboard.
  task automatic issue(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int stalls;
    int want;
    logic [63:0] e;
    e = model(f, a, b, m_hi, m_lo);
    exp_q.push_back(e);
    {m_hi, m_lo} = e;
    want = exp_stall(f, b);
    @(negedge clk);
    start_i = 1'b1; funct_i = f; a_i = a; b_i = b;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall_o) break;
      stalls++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0; funct_i = 6'd0;
    n_tests++;
    if (stalls !== want) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, want);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if ({hi_o, lo_o} !== e || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: got hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0",
               name, hi_o, lo_o, busy_o, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; funct_i = 6'd0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    n_tests++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || stall_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got hi=%h lo=%h stall=%b busy=%b expected all zero", hi_o, lo_o, stall_o, busy_o);
    end
  endtask

  task automatic test_move();
    issue("mthi", FN_MTHI, 32'h12345678, 32'h0);
    issue("mtlo", FN_MTLO, 32'h9ABCDEF0, 32'h0);
    issue("other_funct", 6'b100000, 32'hDEADBEEF, 32'h1);
  endtask

  task automatic test_mult();
    issue("mult_neg", FN_MULT, 32'hFFFFFFFE, 32'd3);
    issue("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue("mult_minmin", FN_MULT, 32'h80000000, 32'h80000000);
  endtask

  task automatic test_div();
    issue("div_neg", FN_DIV, 32'hFFFFFFF9, 32'd2);
    issue("divu_100_7", FN_DIVU, 32'd100, 32'd7);
    issue("div_overflow", FN_DIV, 32'h80000000, 32'hFFFFFFFF);
    issue("div_pos_neg", FN_DIV, 32'd100, 32'hFFFFFFF9);
    issue("divu_big", FN_DIVU, 32'hFFFFFFFF, 32'd1);
  endtask

  task automatic test_div_zero();
    issue("pre_hi", FN_MTHI, 32'h5A5A5A5A, 32'h0);
    issue("pre_lo", FN_MTLO, 32'h5A5A5A5A, 32'h0);
    issue("divu_zero", FN_DIVU, 32'h1234, 32'h0);
    issue("div_zero", FN_DIV, 32'hFFFF0000, 32'h0);
  endtask

  task automatic test_abort(input bit use_rst);
    string name;
    name = use_rst ? "rst_mid_div" : "flush_mid_div";
    issue("abort_pre_hi", FN_MTHI, 32'hCAFEF00D, 32'h0);
    issue("abort_pre_lo", FN_MTLO, 32'h0BADBEEF, 32'h0);
    @(negedge clk);
    start_i = 1'b1; funct_i = FN_DIVU; a_i = 32'd1000; b_i = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    n_tests++;
    if (stall_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_div: got stall=%b busy=%b expected stall=1 busy=1", name, stall_o, busy_o);
    end
    if (use_rst) rst = 1'b1;
    else flush_i = 1'b1;
    #1;
    if (!use_rst) begin
      n_tests++;
      if (stall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall: got %b expected 0", name, stall_o);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; flush_i = 1'b0; start_i = 1'b0; funct_i = 6'd0;
    if (use_rst) begin
      m_hi = '0; m_lo = '0;
    end
    exp_q.push_back({m_hi, m_lo});
    @(negedge clk);
    begin
      logic [63:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (busy_o !== 1'b0 || {hi_o, lo_o} !== e) begin
        n_fail++;
        $display("FAIL %s after: got busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                 name, busy_o, hi_o, lo_o, e[63:32], e[31:0]);
      end
    end
    issue("post_abort_divu", FN_DIVU, 32'd1000, 32'd3);
  endtask

  task automatic test_back_to_back();
    logic [5:0] fl [6];
    logic [5:0] f;
    logic [31:0] a;
    logic [31:0] b;
    fl[0] = FN_MULT; fl[1] = FN_MULTU; fl[2] = FN_DIV;
    fl[3] = FN_DIVU; fl[4] = FN_MTHI;  fl[5] = FN_MTLO;
    for (int i = 0; i < 12; i++) begin
      f = fl[$urandom_range(0, 5)];
      a = $urandom();
      b = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom();
      issue($sformatf("rand_%0d", i), f, a, b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_move();
    test_mult();
    test_div();
    test_div_zero();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
